// File: rtl/mips_alu_pkg.sv
// Shared constants for the MIPS decode/ALU slice: opcodes, funct codes,
// ALU control codes, alu_op classes and the main-control bundle.
package mips_alu_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SLL = 4'b0011,
        ALU_SRL = 4'b0100,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100,
        ALU_INV = 4'b1111
    } alu_ctl_e;

    typedef enum logic [1:0] {
        AOP_ADD   = 2'b00,
        AOP_SUB   = 2'b01,
        AOP_FUNCT = 2'b10,
        AOP_RSVD  = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic    reg_dst;
        logic    branch;
        logic    mem_read;
        logic    mem_to_reg;
        logic    mem_write;
        logic    alu_src;
        logic    reg_write;
        alu_op_e alu_op;
    } ctrl_t;

endpackage

// File: rtl/mips_alu_core.sv
// Pure combinational 32-bit ALU with zero flag. The shifter exists only
// when MIPS_ALU_SHIFT_EN is defined.
module mips_alu_core
    import mips_alu_pkg::*;
(
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [3:0]  alu_ctl,
    input  logic [4:0]  shamt,
    output logic [31:0] result,
    output logic        zero
);

`ifndef MIPS_ALU_SHIFT_EN
    logic unused_shamt;
    assign unused_shamt = ^shamt;
`endif

    always_comb begin
        result = '0;
        case (alu_ctl)
            ALU_ADD: result = src_a + src_b;
            ALU_SUB: result = src_a - src_b;
            ALU_AND: result = src_a & src_b;
            ALU_OR:  result = src_a | src_b;
            ALU_NOR: result = ~(src_a | src_b);
            ALU_SLT: result = {31'd0, $signed(src_a) < $signed(src_b)};
`ifdef MIPS_ALU_SHIFT_EN
            ALU_SLL: result = src_b << shamt;
            ALU_SRL: result = src_b >> shamt;
`endif
            default: result = '0;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/mips_alu_ctrl.sv
// Main control decode, ALU control decode, ALU core and the EX/MEM result
// register. sll/srl decode is present only with MIPS_ALU_SHIFT_EN.
module mips_alu_ctrl
    import mips_alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [4:0]  shamt,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        reg_dst,
    output logic        branch,
    output logic        mem_read,
    output logic        mem_to_reg,
    output logic        mem_write,
    output logic        alu_src,
    output logic        reg_write,
    output logic [1:0]  alu_op,
    output logic [3:0]  alu_ctl,
    output logic [31:0] result,
    output logic        zero,
    output logic [31:0] result_q,
    output logic        zero_q
);

    ctrl_t       ctrl;
    logic [31:0] result_d;
    logic        zero_d;

    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = AOP_ADD;
        case (opcode)
            OP_R: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = AOP_FUNCT;
            end
            OP_LW: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = AOP_SUB;
            end
            OP_ADDI: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign reg_dst    = ctrl.reg_dst;
    assign branch     = ctrl.branch;
    assign mem_read   = ctrl.mem_read;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign mem_write  = ctrl.mem_write;
    assign alu_src    = ctrl.alu_src;
    assign reg_write  = ctrl.reg_write;
    assign alu_op     = ctrl.alu_op;

    // The reserved class 11 falls back to add, like the memory ops.
    always_comb begin
        alu_ctl = ALU_ADD;
        case (ctrl.alu_op)
            AOP_SUB: alu_ctl = ALU_SUB;
            AOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_ctl = ALU_ADD;
                    FN_SUB:  alu_ctl = ALU_SUB;
                    FN_AND:  alu_ctl = ALU_AND;
                    FN_OR:   alu_ctl = ALU_OR;
                    FN_NOR:  alu_ctl = ALU_NOR;
                    FN_SLT:  alu_ctl = ALU_SLT;
`ifdef MIPS_ALU_SHIFT_EN
                    FN_SLL:  alu_ctl = ALU_SLL;
                    FN_SRL:  alu_ctl = ALU_SRL;
`endif
                    default: alu_ctl = ALU_INV;
                endcase
            end
            default: alu_ctl = ALU_ADD;
        endcase
    end

    mips_alu_core u_core (
        .src_a   (src_a),
        .src_b   (src_b),
        .alu_ctl (alu_ctl),
        .shamt   (shamt),
        .result  (result),
        .zero    (zero)
    );

    always_comb begin
        result_d = result_q;
        zero_d   = zero_q;
        if (en) begin
            result_d = result;
            zero_d   = zero;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

endmodule

// File: tb/tb_mips_alu_ctrl.sv
// Scoreboard bench for mips_alu_ctrl: the driver pushes model expectations,
// a monitor pops and compares combinational and registered outputs.
module tb_mips_alu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
    logic [1:0]  alu_op;
    logic [3:0]  alu_ctl;
    logic [31:0] result;
    logic        zero;
    logic [31:0] result_q;
    logic        zero_q;

    typedef struct packed {
        logic [8:0]  ctrl;
        logic [3:0]  ctl;
        logic [31:0] res;
        logic        zero;
    } comb_exp_t;

    comb_exp_t   comb_q[$];
    logic [32:0] exp_q[$];
    logic [32:0] model_reg;
    int          n_tests;
    int          n_fail;
    bit          mon_on;

`ifdef MIPS_ALU_SHIFT_EN
    localparam bit SHIFT_ON = 1'b1;
`else
    localparam bit SHIFT_ON = 1'b0;
`endif

    mips_alu_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .opcode     (opcode),
        .funct      (funct),
        .shamt      (shamt),
        .src_a      (src_a),
        .src_b      (src_b),
        .reg_dst    (reg_dst),
        .branch     (branch),
        .mem_read   (mem_read),
        .mem_to_reg (mem_to_reg),
        .mem_write  (mem_write),
        .alu_src    (alu_src),
        .reg_write  (reg_write),
        .alu_op     (alu_op),
        .alu_ctl    (alu_ctl),
        .result     (result),
        .zero       (zero),
        .result_q   (result_q),
        .zero_q     (zero_q)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Control bundle order: reg_dst branch mem_read mem_to_reg mem_write alu_src reg_write alu_op[1:0]
    function automatic logic [8:0] model_ctrl(input logic [5:0] op);
        case (op)
            6'd0:  return {7'b1000001, 2'd2};
            6'd35: return {7'b0011011, 2'd0};
            6'd43: return {7'b0000110, 2'd0};
            6'd4:  return {7'b0100000, 2'd1};
            6'd8:  return {7'b0000011, 2'd0};
            default: return 9'd0;
        endcase
    endfunction

    function automatic logic [3:0] model_ctl(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'd4) return 4'd6;
        if (op != 6'd0) return 4'd2;
        case (fn)
            6'd32: return 4'd2;
            6'd34: return 4'd6;
            6'd36: return 4'd0;
            6'd37: return 4'd1;
            6'd39: return 4'd12;
            6'd42: return 4'd7;
            6'd0:  return SHIFT_ON ? 4'd3 : 4'd15;
            6'd2:  return SHIFT_ON ? 4'd4 : 4'd15;
            default: return 4'd15;
        endcase
    endfunction

    function automatic logic [31:0] model_alu(input logic [3:0] ctl, input logic [4:0] sh,
                                              input logic [31:0] a, input logic [31:0] b);
        longint ua, ub, sa, sb, m;
        m  = 64'h1_0000_0000;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = a[31] ? ua - m : ua;
        sb = b[31] ? ub - m : ub;
        case (ctl)
            4'd2:  return 32'((ua + ub) % m);
            4'd6:  return 32'((ua - ub + m) % m);
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd12: return ~(a | b);
            4'd7:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd3:  return 32'((ub * (64'd1 << sh)) % m);
            4'd4:  return 32'(ub / (64'd1 << sh));
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b, input logic e);
        comb_exp_t x;
        @(posedge clk);
        #2;
        opcode = op; funct = fn; shamt = sh; src_a = a; src_b = b; en = e;
        x.ctrl = model_ctrl(op);
        x.ctl  = model_ctl(op, fn);
        x.res  = model_alu(x.ctl, sh, a, b);
        x.zero = (x.res == 32'd0);
        comb_q.push_back(x);
        if (e) model_reg = {x.zero, x.res};
        exp_q.push_back(model_reg);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((comb_q.size() != 0 || exp_q.size() != 0) && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        @(posedge clk);
        #3;
        check("drain_timeout", 32'(comb_q.size() + exp_q.size()), 32'd0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        comb_exp_t   c;
        logic [32:0] r;
        wait (mon_on);
        forever begin
            @(negedge clk);
            if (comb_q.size() != 0) begin
                c = comb_q.pop_front();
                check("ctrl", 32'({reg_dst, branch, mem_read, mem_to_reg, mem_write,
                                   alu_src, reg_write, alu_op}), 32'(c.ctrl));
                check("alu_ctl", 32'(alu_ctl), 32'(c.ctl));
                check("result", result, c.res);
                check("zero", 32'(zero), 32'(c.zero));
            end
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                r = exp_q.pop_front();
                check("result_q", result_q, r[31:0]);
                check("zero_q", 32'(zero_q), 32'(r[32]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0] ops[6];
        logic [5:0] fns[9];
        logic [5:0] op, fn;
        logic [31:0] a, b;
        n_tests = 0; n_fail = 0; mon_on = 1'b0;
        model_reg = '0;
        ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd63};
        fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd0, 6'd2, 6'd63};

        rst_n = 1'b1; en = 1'b1; opcode = 6'd0; funct = 6'd32; shamt = 5'd0;
        src_a = 32'd3; src_b = 32'd4;
        #1 rst_n = 1'b0;
        #2;
        check("reset_result_q", result_q, 32'd0);
        check("reset_zero_q", 32'(zero_q), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold_result_q", result_q, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mon_on = 1'b1;

        // directed: add 3+4 first load, opcode sweep, R-type table
        drive(6'd0,  6'd32, 5'd0, 32'd3, 32'd4, 1'b1);
        drive(6'd35, 6'd0,  5'd0, 32'h100, 32'h20, 1'b1);
        drive(6'd4,  6'd0,  5'd0, 32'h5, 32'h5, 1'b1);
        drive(6'd63, 6'd0,  5'd0, 32'h5, 32'h6, 1'b1);
        drive(6'd43, 6'd0,  5'd0, 32'h10, 32'h4, 1'b1);
        drive(6'd8,  6'd0,  5'd0, 32'hFFFFFFFF, 32'h1, 1'b1);
        for (int i = 0; i < 9; i++)
            drive(6'd0, fns[i], 5'd3, 32'h0000000C, 32'h0000000A, 1'b1);
        drive(6'd0, 6'd42, 5'd0, 32'hFFFFFFFF, 32'h1, 1'b1);
        drive(6'd0, 6'd42, 5'd0, 32'h1, 32'hFFFFFFFF, 1'b1);
        drive(6'd4, 6'd0, 5'd0, 32'h1234, 32'h1234, 1'b1);
        drive(6'd4, 6'd0, 5'd0, 32'h1234, 32'h1235, 1'b0);
        drive(6'd4, 6'd0, 5'd0, 32'h1234, 32'h1235, 1'b0);
        drive(6'd0, 6'd0, 5'd31, 32'h0, 32'h1, 1'b1);
        drive(6'd0, 6'd2, 5'd4, 32'h0, 32'h80000000, 1'b1);

        // random
        for (int i = 0; i < 300; i++) begin
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
            fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 8)];
            a  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 15)) - 32'd8;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            drive(op, fn, 5'($urandom), a, b, $urandom_range(0, 3) != 0);
        end

        // mid-cycle asynchronous reset after a non-zero load
        drive(6'd0, 6'd32, 5'd0, 32'd3, 32'd4, 1'b1);
        drain();
        check("pre_reset_result_q", result_q, 32'd7);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_result_q", result_q, 32'd0);
        check("async_reset_zero_q", 32'(zero_q), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reg = '0;
        drive(6'd0, 6'd32, 5'd0, 32'd3, 32'd4, 1'b1);
        drive(6'd0, 6'd34, 5'd0, 32'd9, 32'd9, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_alu_ctrl.md
# mips_alu_ctrl

Combined decode-and-execute block for the MIPS pipeline: main control decode (opcode → pipeline control signals), ALU control (ALU op class + funct → 4-bit ALU operation) and a 32-bit ALU with zero flag. Decode and ALU paths are combinational. A result/zero register captures the ALU output for the EX/MEM boundary. Sits between the ID/EX register and the EX/MEM register; `zero` drives the branch AND gate.

## Interface
- No parameters; widths fixed at 32-bit data, 6-bit opcode/funct, 5-bit shamt.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `en` input 1: load enable for `result_q`/`zero_q`.
- `opcode` input 6: instruction [31:26].
- `funct` input 6: instruction [5:0].
- `shamt` input 5: instruction [10:6].
- `src_a` input 32: ALU operand A (forwarded rs).
- `src_b` input 32: ALU operand B (rt or immediate, selected upstream).
- `reg_dst`, `branch`, `mem_read`, `mem_to_reg`, `mem_write`, `alu_src`, `reg_write` output 1 each: main control.
- `alu_op` output 2: op class, 00 add / 01 sub / 10 funct.
- `alu_ctl` output 4: decoded ALU operation.
- `result` output 32: combinational ALU result.
- `zero` output 1: combinational, `result == 0`.
- `result_q` output 32, `zero_q` output 1: registered copies.

## Operation
- Main decode:
  - 000000 R-type: reg_dst=1, reg_write=1, alu_op=10.
  - 100011 lw: alu_src=1, mem_to_reg=1, reg_write=1, mem_read=1, alu_op=00.
  - 101011 sw: alu_src=1, mem_write=1, alu_op=00.
  - 000100 beq: branch=1, alu_op=01.
  - 001000 addi: alu_src=1, reg_write=1, alu_op=00.
  - Any other opcode: all controls 0, alu_op=00.
- ALU control:
  - alu_op 00 → 0010 add; 01 → 0110 sub; 11 → 0010 add.
  - alu_op 10, by funct: 100000 → 0010 add; 100010 → 0110 sub; 100100 → 0000 and; 100101 → 0001 or; 100111 → 1100 nor; 101010 → 0111 slt; 000000 → 0011 sll; 000010 → 0100 srl.
  - Any other funct → 1111 invalid.
- ALU, using the ALU control codes above:
  - 0010: `a+b`, mod 2^32, no overflow flag.
  - 0110: `a-b`, mod 2^32.
  - 0000: `a&b`. 0001: `a|b`. 1100: `~(a|b)`.
  - 0111: 1 if `a<b` signed, else 0.
  - 0011: `b<<shamt`. 0100: `b>>shamt`, logical.
  - 1111 or any unlisted code: result 0.
- `zero` is asserted whenever the result is 0, regardless of operation.

## Timing
- Control, `alu_ctl`, `result` and `zero` are combinational from inputs, with zero latency.
- Rising `clk` with `en=1`: `result_q` ← `result`, `zero_q` ← `zero`, giving 1-cycle latency. With `en=0` both hold their value.
- `rst_n` low: `result_q`=0 and `zero_q`=0 immediately, independent of `clk`. Release is synchronous to the next edge, and the first load occurs at the first rising edge with `rst_n` high.
- Reset has no effect on the combinational outputs.

## Configuration
- `MIPS_ALU_SHIFT_EN` defined: sll/srl funct decode (0011/0100) and the shifter are present.
- `MIPS_ALU_SHIFT_EN` undefined: funct 000000/000010 decode to 1111, result is 0, and no shifter logic is present.

## Structure
- Package `mips_alu_pkg` holds:
  - opcode constants (R, LW, SW, BEQ, ADDI);
  - funct constants;
  - 4-bit ALU control codes;
  - 2-bit alu_op encodings.
- Sub-module `mips_alu_core` holds the pure combinational datapath: `src_a`, `src_b`, `alu_ctl`, `shamt` → `result`, `zero`.
- The top level contains the two decoders and the output register.

## Test plan
- Reset: `rst_n`=0 mid-cycle → `result_q`=0, `zero_q`=0 immediately. After release, `en`=1 with add of 3+4 → `result_q`=7 after one edge.
- Opcode sweep:
  - lw → reg_write, mem_read, mem_to_reg, alu_src =1, alu_op=00.
  - beq → branch=1, alu_op=01.
  - 111111 → all controls 0.
- R-type, a=0x0000000C, b=0x0000000A:
  - add → 0x16; sub → 0x2; and → 0x8; or → 0xE; nor → 0xFFFFFFF1.
  - funct 111111 → `alu_ctl`=1111, result 0, `zero`=1.
- slt with a=0xFFFFFFFF (−1), b=1 → result 1. With a=1, b=0xFFFFFFFF → result 0.
- beq with a=b=0x1234 → sub result 0, `zero`=1. With a=0x1234, b=0x1235 → `zero`=0. Hold `en`=0 → `zero_q` keeps its previous value.
- With `MIPS_ALU_SHIFT_EN`:
  - sll, b=1, shamt=31 → 0x80000000.
  - srl, b=0x80000000, shamt=4 → 0x08000000.
  - Without the macro both give 0.
